symm_decorr_ctrl: RTL

Sequencing controller for the 4x4 symmetric W·Wᵀ multiplier in the FastICA symmetric-decorrelation loop. Per iteration it:
- fires the multiplier for one cycle;
- scans the resulting Q13 product matrix C for its largest deviation from identity;
- either finishes, or hands off to the external W-update unit and loops.

It sits between the top-level ICA sequencer (start/done) and the multiplier plus update datapath. It holds no matrix storage.

---
 rtl/symm_pkg.sv | 39 +++
 rtl/q13_absdev.sv | 23 ++
 rtl/symm_decorr_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/symm_pkg.sv
// Shared constants and types for the symmetric-decorrelation controller.
package symm_pkg;

    localparam int DW       = 26;
    localparam int FRAC     = 13;
    localparam logic signed [DW-1:0] ONE_Q = DW'(1 << FRAC);
    localparam int SCAN_LEN = 10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_SCAN     = 3'd2,
        S_DECIDE   = 3'd3,
        S_UPD      = 3'd4,
        S_UPD_WAIT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    // Upper triangle of the 4x4 matrix, row-major, diagonal included.
    localparam rc_t TRI_RC [SCAN_LEN] = '{
        '{2'd0, 2'd0}, '{2'd0, 2'd1}, '{2'd0, 2'd2}, '{2'd0, 2'd3},
        '{2'd1, 2'd1}, '{2'd1, 2'd2}, '{2'd1, 2'd3},
        '{2'd2, 2'd2}, '{2'd2, 2'd3},
        '{2'd3, 2'd3}
    };

    // Scan index to (row,col); out-of-range indices fold onto entry 0.
    function automatic rc_t tri_lookup(input logic [3:0] idx);
        rc_t rc;
        rc = (idx < 4'(SCAN_LEN)) ? TRI_RC[idx] : TRI_RC[0];
        return rc;
    endfunction

endpackage

// File: rtl/q13_absdev.sv
// Combinational saturated absolute deviation |x - ref| for Q13 elements.
module q13_absdev #(
    parameter int DW = symm_pkg::DW
) (
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_ref,
    output logic        [DW-2:0] o_dev
);

    // Largest magnitude representable in the DW-1 bit result.
    localparam logic [DW:0] SAT = {2'b00, {(DW-1){1'b1}}};

    logic signed [DW:0] w_diff;
    logic        [DW:0] w_mag;

    // One extra bit keeps the difference and its negation exact before clipping.
    always_comb begin
        w_diff = {i_x[DW-1], i_x} - {i_ref[DW-1], i_ref};
        w_mag  = w_diff[DW] ? -w_diff : w_diff;
        o_dev  = (w_mag > SAT) ? SAT[DW-2:0] : w_mag[DW-2:0];
    end

endmodule

// File: rtl/symm_decorr_ctrl.sv
// Sequencer for the W*W^T multiplier: fire, scan C against identity, decide, update, loop.
module symm_decorr_ctrl #(
    parameter int DW       = symm_pkg::DW,
    parameter int FRAC     = symm_pkg::FRAC,
    parameter int MAX_ITER = 8,
    parameter int TOL      = 16,
    localparam int IW      = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1
) (
    input  logic                clk_sdc,
    input  logic                rst_n_sdc,
    input  logic                start,
    input  logic [16*DW-1:0]    c_flat,
    output logic                mul_en,
    output logic                upd_start,
    input  logic                upd_done,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic [IW-1:0]       iter_cnt,
    output logic [DW-2:0]       err_max
);

    import symm_pkg::*;

    localparam logic signed [DW-1:0] ONE_REF = DW'(1 << FRAC);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_idx;
    logic [IW-1:0]      r_iter;
    logic [DW-2:0]      r_err_max;
    logic               r_conv;

    logic signed [DW-1:0] w_elem [16];
    rc_t                  w_rc;
    logic [3:0]           w_sel_idx;
    logic                 w_is_diag;
    logic signed [DW-1:0] w_sel;
    logic signed [DW-1:0] w_ref;
    logic [DW-2:0]        w_dev;
    logic                 w_tol_met;
    logic                 w_iter_max;
    logic                 w_mul_en;
    logic                 w_upd_start;
    logic                 w_done;

    // Unpack the flat product matrix into addressable elements.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
            assign w_elem[gi] = $signed(c_flat[gi*DW +: DW]);
        end
    endgenerate

    // Select the element under the scan index and its identity reference.
    always_comb begin
        w_rc      = tri_lookup(r_idx);
        w_sel_idx = {w_rc.row, w_rc.col};
        w_is_diag = (w_rc.row == w_rc.col);
        w_sel     = w_elem[w_sel_idx];
        w_ref     = w_is_diag ? ONE_REF : '0;
    end

    q13_absdev #(
        .DW(DW)
    ) u_absdev (
        .i_x   (w_sel),
        .i_ref (w_ref),
        .o_dev (w_dev)
    );

    assign w_tol_met  = (r_err_max < (DW-1)'(TOL));
    assign w_iter_max = (r_iter == IW'(MAX_ITER));

    // Next-state and strobe decode.
    always_comb begin
        w_state_next = r_state;
        w_mul_en     = 1'b0;
        w_upd_start  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_MUL;
            end
            S_MUL: begin
                w_mul_en     = 1'b1;
                w_state_next = S_SCAN;
            end
            S_SCAN: begin
                if (r_idx == 4'(SCAN_LEN - 1)) w_state_next = S_DECIDE;
            end
            S_DECIDE: begin
                // Convergence wins over the iteration limit.
                if (w_tol_met || w_iter_max) w_state_next = S_DONE;
                else                         w_state_next = S_UPD;
            end
            S_UPD: begin
                w_upd_start  = 1'b1;
                w_state_next = S_UPD_WAIT;
            end
            S_UPD_WAIT: begin
                if (upd_done) w_state_next = S_MUL;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_sdc or negedge rst_n_sdc) begin
        if (!rst_n_sdc) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Scan index: zeroed while the multiplier fires, walks 0..9 during SCAN.
    always_ff @(posedge clk_sdc or negedge rst_n_sdc) begin
        if (!rst_n_sdc)               r_idx <= '0;
        else if (r_state == S_MUL)    r_idx <= '0;
        else if (r_state == S_SCAN)   r_idx <= r_idx + 4'd1;
    end

    // Running maximum deviation; cleared when a new product is requested.
    always_ff @(posedge clk_sdc or negedge rst_n_sdc) begin
        if (!rst_n_sdc)                                  r_err_max <= '0;
        else if (r_state == S_MUL)                       r_err_max <= '0;
        else if (r_state == S_SCAN && w_dev > r_err_max) r_err_max <= w_dev;
    end

    // Completed-update counter; cleared on an accepted start.
    always_ff @(posedge clk_sdc or negedge rst_n_sdc) begin
        if (!rst_n_sdc)                               r_iter <= '0;
        else if (r_state == S_IDLE && start)          r_iter <= '0;
        else if (r_state == S_UPD_WAIT && upd_done)   r_iter <= r_iter + IW'(1);
    end

    // Convergence flag; only an accepted start or a passing DECIDE touches it.
    always_ff @(posedge clk_sdc or negedge rst_n_sdc) begin
        if (!rst_n_sdc)                          r_conv <= 1'b0;
        else if (r_state == S_IDLE && start)     r_conv <= 1'b0;
        else if (r_state == S_DECIDE && w_tol_met) r_conv <= 1'b1;
    end

    assign mul_en    = w_mul_en;
    assign upd_start = w_upd_start;
    assign done      = w_done;
    assign busy      = (r_state != S_IDLE);
    assign converged = r_conv;
    assign iter_cnt  = r_iter;
    assign err_max   = r_err_max;

endmodule
